// File: rtl/dag_pkg.sv
// Shared constants and group encodings for the DAG index/modify/length path.
package dag_pkg;

   localparam int AW   = 14;            // address / register width (matches modulo adder)
   localparam int NREG = 4;             // registers per I/M/L set
   localparam int IW   = $clog2(NREG);  // register index width

   // Register group selector used by the host write and readback ports.
   typedef enum logic [1:0] {
      GRP_I   = 2'b00,
      GRP_M   = 2'b01,
      GRP_L   = 2'b10,
      GRP_RSV = 2'b11
   } grp_e;

endpackage

// File: rtl/dag_regset.sv
// NREG x AW register file: two write ports (port a has priority over port b
// on the same index) and two asynchronous read ports.
module dag_regset #(
   parameter  int AW   = 14,
   parameter  int NREG = 4,
   localparam int XW   = $clog2(NREG)
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          wa_en,
   input  logic [XW-1:0] wa_idx,
   input  logic [AW-1:0] wa_data,
   input  logic          wb_en,
   input  logic [XW-1:0] wb_idx,
   input  logic [AW-1:0] wb_data,
   input  logic [XW-1:0] ra_idx,
   output logic [AW-1:0] ra_data,
   input  logic [XW-1:0] rb_idx,
   output logic [AW-1:0] rb_data
);

   logic [AW-1:0] mem [NREG];

   // Register storage; port a is assigned last so it wins a same-index collision.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         // NOTE: this array is reset because every register must read 0 after
         // reset; it is a small flop bank, not an inferred RAM macro.
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments for state; with two writes to the
         // same element in one block, the later one in program order sticks.
         if (wb_en) mem[wb_idx] <= wb_data;
         if (wa_en) mem[wa_idx] <= wa_data;
      end
   end

   assign ra_data = mem[ra_idx];
   assign rb_data = mem[rb_idx];

endmodule

// File: rtl/dag_index_sequencer.sv
// DAG modulo-path sequencer: I/M/L register banks, one-entry request stage
// driving the external modulo adder, index writeback and sticky wrap status.
module dag_index_sequencer #(
   parameter  int AW   = dag_pkg::AW,
   parameter  int NREG = dag_pkg::NREG,
   localparam int XW   = $clog2(NREG)
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            wr_en,
   input  logic [1:0]      wr_grp,
   input  logic [XW-1:0]   wr_idx,
   input  logic [AW-1:0]   wr_data,
   input  logic [1:0]      rd_grp,
   input  logic [XW-1:0]   rd_idx,
   output logic [AW-1:0]   rd_data,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XW-1:0]   req_isel,
   input  logic [XW-1:0]   req_msel,
   output logic [AW-1:0]   mod_I,
   output logic [AW-1:0]   mod_M,
   output logic [AW-1:0]   mod_L,
   input  logic [AW-1:0]   mod_newI,
   input  logic            mod_wrap,
   output logic            addr_valid,
   input  logic            addr_ready,
   output logic [AW-1:0]   addr,
   output logic            addr_wrap,
   output logic [NREG-1:0] wrap_sticky
);

   import dag_pkg::*;

   // In-flight access: operands are frozen at acceptance.
   typedef struct packed {
      logic          valid;
      logic [XW-1:0] isel;
      logic [AW-1:0] ival;
      logic [AW-1:0] mval;
      logic [AW-1:0] lval;
   } stage_t;

   stage_t        s;
   logic          xfer, accept;
   logic          wr_i, wr_m, wr_l;
   logic [AW-1:0] i_req, m_req, l_req;
   logic [AW-1:0] i_rd, m_rd, l_rd;
   logic [AW-1:0] ival_nxt, mval_nxt, lval_nxt;

   assign xfer      = s.valid & addr_ready;
   assign req_ready = ~s.valid | addr_ready;
   assign accept    = req_valid & req_ready;

   // Reserved group decodes to no write at all.
   assign wr_i = wr_en && (wr_grp == GRP_I);
   assign wr_m = wr_en && (wr_grp == GRP_M);
   assign wr_l = wr_en && (wr_grp == GRP_L);

   // Index bank: host write (port a) beats the adder writeback (port b).
   dag_regset #(.AW(AW), .NREG(NREG)) u_iset (
      .CLK(CLK), .RSTn(RSTn),
      .wa_en(wr_i), .wa_idx(wr_idx), .wa_data(wr_data),
      .wb_en(xfer), .wb_idx(s.isel), .wb_data(mod_newI),
      .ra_idx(req_isel), .ra_data(i_req),
      .rb_idx(rd_idx), .rb_data(i_rd)
   );

   dag_regset #(.AW(AW), .NREG(NREG)) u_mset (
      .CLK(CLK), .RSTn(RSTn),
      .wa_en(wr_m), .wa_idx(wr_idx), .wa_data(wr_data),
      .wb_en(1'b0), .wb_idx('0), .wb_data('0),
      .ra_idx(req_msel), .ra_data(m_req),
      .rb_idx(rd_idx), .rb_data(m_rd)
   );

   // Length is indexed by the I selector, not the M selector.
   dag_regset #(.AW(AW), .NREG(NREG)) u_lset (
      .CLK(CLK), .RSTn(RSTn),
      .wa_en(wr_l), .wa_idx(wr_idx), .wa_data(wr_data),
      .wb_en(1'b0), .wb_idx('0), .wb_data('0),
      .ra_idx(req_isel), .ra_data(l_req),
      .rb_idx(rd_idx), .rb_data(l_rd)
   );

   // Operand capture with forwarding of same-edge updates (host write highest).
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch forms.
      ival_nxt = i_req;
      mval_nxt = m_req;
      lval_nxt = l_req;
      if (xfer && (s.isel == req_isel)) ival_nxt = mod_newI;
      if (wr_i && (wr_idx == req_isel)) ival_nxt = wr_data;
      if (wr_m && (wr_idx == req_msel)) mval_nxt = wr_data;
      if (wr_l && (wr_idx == req_isel)) lval_nxt = wr_data;
   end

   // Stage register: load on accept, drain on transfer, hold while stalled.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         s <= '0;
      end else if (accept) begin
         s <= '{valid: 1'b1, isel: req_isel, ival: ival_nxt,
                mval: mval_nxt, lval: lval_nxt};
      end else if (xfer) begin
         s.valid <= 1'b0;
      end
   end

   // Sticky wrap per index register; a host write to I[k] clears it and wins.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wrap_sticky <= '0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (wr_i && (wr_idx == XW'(k)))
               wrap_sticky[k] <= 1'b0;
            else if (xfer && mod_wrap && (s.isel == XW'(k)))
               wrap_sticky[k] <= 1'b1;
         end
      end
   end

   // Registered readback of the current register state (no same-edge bypass).
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rd_data <= '0;
      end else begin
         case (grp_e'(rd_grp))
            GRP_I:   rd_data <= i_rd;
            GRP_M:   rd_data <= m_rd;
            GRP_L:   rd_data <= l_rd;
            default: rd_data <= '0;
         endcase
      end
   end

   assign addr_valid = s.valid;
   assign addr       = s.ival;
   assign addr_wrap  = s.valid & mod_wrap;
   assign mod_I      = s.ival;
   assign mod_M      = s.mval;
   assign mod_L      = s.lval;

endmodule
